pipeline_ctrl: RTL and testbench

Hazard and stall controller for the five-stage in-order pipeline. It generates the pause and bubble controls for the PC register and the if_id, id_ex, ex_mem and mem_wb pipeline registers. It resolves, in priority order, four conditions: data-memory wait states, multi-cycle mul/div occupancy, taken-branch flush and load-use hazards. It also keeps a memory-wait watchdog and a stall-cycle performance counter.

---
 rtl/pipeline_ctrl.sv | 110 +++++++++++
 tb/tb_pipeline_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall controller producing pause and bubble controls for a five-stage pipeline,
// with a memory-wait watchdog and a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             muldiv_start,
    input  logic             muldiv_done,
    output logic             pc_pause,
    output logic             if_id_pause,
    output logic             if_id_bubble,
    output logic             id_ex_pause,
    output logic             id_ex_bubble,
    output logic             ex_mem_pause,
    output logic             ex_mem_bubble,
    output logic             mem_wb_pause,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, MD_BUSY} state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] WD_MAX  = TO_W'(MEM_TIMEOUT);

    state_t          state;
    logic            md_pend;
    logic            md_done_l;
    logic [TO_W-1:0] wd;

    logic mem_stall, md_fin, md_busy, md_stall, lu_hazard, rst;
    logic r_mem, r_md, r_br, r_lu;

    assign rst       = ~reset_n;
    assign mem_stall = mem_req & ~mem_ready;
    // a done seen during a memory stall is held until the stall releases
    assign md_fin    = muldiv_done | md_done_l;
    assign md_busy   = (state == MD_BUSY | md_pend) & ~md_fin;
    assign md_stall  = muldiv_start | md_busy;
    assign lu_hazard = ex_is_load & (ex_rd != 5'd0) &
                       ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

    assign r_mem = mem_stall;
    assign r_md  = ~mem_stall & md_stall;
    assign r_br  = ~mem_stall & ~md_stall & branch_taken;
    assign r_lu  = ~mem_stall & ~md_stall & ~branch_taken & lu_hazard;

    assign pc_pause      = rst | r_mem | r_md | r_lu;
    assign if_id_pause   = ~rst & (r_mem | r_md | r_lu);
    assign if_id_bubble  = rst | r_br;
    assign id_ex_pause   = ~rst & (r_mem | r_md);
    assign id_ex_bubble  = rst | r_br | r_lu;
    assign ex_mem_pause  = ~rst & r_mem;
    assign ex_mem_bubble = rst | r_md;
    assign mem_wb_pause  = 1'b0;
    assign mem_wb_bubble = rst | r_mem;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            md_pend      <= 1'b0;
            md_done_l    <= 1'b0;
            wd           <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            wd        <= ~mem_stall ? '0 : (wd == WD_MAX) ? wd : wd + 1'b1;
            md_done_l <= mem_stall & (md_done_l | (muldiv_done & (state == MD_BUSY | md_pend)));
            if (mem_stall && wd == WD_LAST)
                mem_timeout <= 1'b1;
            if (pc_pause && ~&stall_cycles)
                stall_cycles <= stall_cycles + 1'b1;
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state   <= MEM_WAIT;
                        md_pend <= muldiv_start;
                    end else if (muldiv_start) begin
                        state <= MD_BUSY;
                    end
                end
                MEM_WAIT: begin
                    if (mem_stall) begin
                        md_pend <= md_pend | muldiv_start;
                    end else begin
                        state   <= (md_busy | muldiv_start) ? MD_BUSY : RUN;
                        md_pend <= 1'b0;
                    end
                end
                MD_BUSY: begin
                    if (~mem_stall & md_fin)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed stimulus with a queue-based scoreboard checked by an independent monitor.
module tb_pipeline_ctrl;
    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] MEM  = 9'b110101001;
    localparam logic [8:0] MD   = 9'b110100100;
    localparam logic [8:0] BR   = 9'b001010000;
    localparam logic [8:0] LU   = 9'b110010000;
    localparam logic [8:0] RST  = 9'b101010101;
    localparam int CNT_MAX = 31;
    localparam int TO_N    = 4;

    logic clock = 1'b0;
    logic reset_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_rs1_used, id_rs2_used, ex_is_load, branch_taken;
    logic mem_req, mem_ready, muldiv_start, muldiv_done;
    logic pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble;
    logic ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble, mem_timeout;
    logic [4:0] stall_cycles;
    logic [8:0] ctrl;

    typedef struct {
        logic [8:0] ctrl;
        int         cnt;
        logic       to;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int n_chk = 0;
    int n_fail = 0;
    int m_cnt = 0;
    int m_wd = 0;
    logic m_to = 1'b0;

    pipeline_ctrl #(.CNT_W(5), .MEM_TIMEOUT(TO_N), .TO_W(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
        .pc_pause(pc_pause), .if_id_pause(if_id_pause), .if_id_bubble(if_id_bubble),
        .id_ex_pause(id_ex_pause), .id_ex_bubble(id_ex_bubble),
        .ex_mem_pause(ex_mem_pause), .ex_mem_bubble(ex_mem_bubble),
        .mem_wb_pause(mem_wb_pause), .mem_wb_bubble(mem_wb_bubble),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    assign ctrl = {pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
                   ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble};

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (q.size() > 0) begin
            mx = q.pop_front();
            n_chk += 3;
            if (ctrl !== mx.ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl: got %b expected %b", mx.nm, ctrl, mx.ctrl);
            end
            if (int'(stall_cycles) != mx.cnt) begin
                n_fail++;
                $display("FAIL %s stall_cycles: got %0d expected %0d", mx.nm, stall_cycles, mx.cnt);
            end
            if (mem_timeout !== mx.to) begin
                n_fail++;
                $display("FAIL %s mem_timeout: got %b expected %b", mx.nm, mem_timeout, mx.to);
            end
        end
    end

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0; ex_is_load = 0; branch_taken = 0;
        mem_req = 0; mem_ready = 0; muldiv_start = 0; muldiv_done = 0;
    endtask

    task automatic step(input string nm, input logic [8:0] e);
        exp_t x;
        if (!reset_n) begin
            m_cnt = 0; m_wd = 0; m_to = 1'b0;
        end
        x.ctrl = e; x.cnt = m_cnt; x.to = m_to; x.nm = nm;
        q.push_back(x);
        if (reset_n) begin
            if (e[8] && m_cnt < CNT_MAX) m_cnt++;
            if (e == MEM) begin
                m_wd++;
                if (m_wd >= TO_N) m_to = 1'b1;
            end else begin
                m_wd = 0;
            end
        end
        @(posedge clock); #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clr();
        @(posedge clock); #1;
        step("reset", RST);
        reset_n = 1'b1;
        step("idle", NONE);
        // load-use hazards
        ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        step("lu_rs1", LU);
        clr(); step("lu_rel", NONE);
        ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
        step("lu_x0", NONE);
        clr(); ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1;
        step("lu_rs2", LU);
        clr(); ex_is_load = 1; ex_rd = 9; id_rs1 = 9;
        step("lu_unused", NONE);
        // memory wait of 3 cycles, then zero-wait access
        clr(); mem_req = 1;
        repeat (3) step("mem_wait", MEM);
        mem_ready = 1; step("mem_done", NONE);
        step("mem_zero_wait", NONE);
        clr(); step("mem_idle", NONE);
        // 3-cycle runs must not trip the watchdog, 6-cycle run must
        mem_req = 1; repeat (3) step("wd_run3a", MEM);
        clr(); step("wd_gap", NONE);
        mem_req = 1; repeat (3) step("wd_run3b", MEM);
        clr(); step("wd_gap2", NONE);
        mem_req = 1; repeat (6) step("wd_run6", MEM);
        mem_ready = 1; step("wd_release", NONE);
        clr(); step("wd_sticky", NONE);
        // mul/div: start plus 4 busy cycles
        muldiv_start = 1; step("md_start", MD);
        clr(); repeat (4) step("md_busy", MD);
        muldiv_done = 1; step("md_done", NONE);
        clr(); step("md_idle", NONE);
        // priority
        branch_taken = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
        step("prio_br_lu", BR);
        clr(); mem_req = 1; branch_taken = 1;
        step("prio_mem_br", MEM);
        mem_ready = 1; step("prio_mem_rel", BR);
        clr(); step("prio_idle", NONE);
        // done latched during a memory stall inside MD_BUSY
        muldiv_start = 1; step("mdm_start", MD);
        clr(); step("mdm_busy", MD);
        mem_req = 1; muldiv_done = 1; step("mdm_mem_done", MEM);
        muldiv_done = 0; mem_ready = 1; step("mdm_release", NONE);
        clr(); step("mdm_idle", NONE);
        // mul/div started during a memory stall runs after the stall
        mem_req = 1; muldiv_start = 1; step("pend_start", MEM);
        muldiv_start = 0; step("pend_wait", MEM);
        mem_ready = 1; step("pend_md", MD);
        clr(); step("pend_busy", MD);
        muldiv_done = 1; step("pend_done", NONE);
        clr(); step("pend_idle", NONE);
        // reset during MD_BUSY
        muldiv_start = 1; step("rmd_start", MD);
        clr(); step("rmd_busy", MD);
        reset_n = 1'b0; step("rmd_reset", RST);
        reset_n = 1'b1; step("rmd_after", NONE);
        step("rmd_after2", NONE);
        // long stall: watchdog again and counter saturation
        mem_req = 1; repeat (35) step("sat_wait", MEM);
        mem_ready = 1; step("sat_release", NONE);
        clr(); step("sat_idle", NONE);
        repeat (2) @(negedge clock);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
